// File: rtl/axis_ramp_checker.sv
// axis_ramp_checker
// AXI4-Stream sink that checks a wide sample stream is a per-lane incrementing
// ramp. Lane i of a beat must equal lane 0 plus i*STEP. Lane 0 of each beat
// must equal lane 0 of the previous beat plus LANES*STEP. All arithmetic wraps
// modulo 2^SAMPLE_W.
//
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   s_axis_tdata     sample beat, lane i = tdata[i*SAMPLE_W +: SAMPLE_W]
//   s_axis_tvalid    beat valid
//   s_axis_tready    registered ready (enable, optionally gated by an LFSR)
//   enable           allows tready to assert
//   clear            synchronous clear of all status, back to ACQUIRE
//   locked           high while tracking the ramp
//   err_flag         sticky, set on the first bad beat
//   beat_count       accepted beats, saturating
//   err_count        bad beats, saturating
//   first_err_beat   beat_count value of the first bad beat
//   first_err_lane   lowest failing lane of the first bad beat

module axis_ramp_checker #(
    parameter int          DATA_W     = 512,
    parameter int          SAMPLE_W   = 16,
    parameter int          STEP       = 1,
    parameter int          READY_MODE = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          ERR_LIMIT  = 4,
    localparam int         LANES      = DATA_W / SAMPLE_W,
    localparam int         LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              enable,
    input  logic              clear,
    output logic              locked,
    output logic              err_flag,
    output logic [31:0]       beat_count,
    output logic [31:0]       err_count,
    output logic [31:0]       first_err_beat,
    output logic [LANE_W-1:0] first_err_lane
);

    localparam logic [SAMPLE_W-1:0] BEAT_STEP = SAMPLE_W'(LANES * STEP);
    localparam logic [31:0]         LIMIT_M1  = 32'(ERR_LIMIT - 1);

    typedef enum logic {ACQUIRE, TRACK} state_t;

    state_t              state, state_next;
    logic [15:0]         lfsr;
    logic                lfsr_fb;
    logic                ready_bit;
    logic                accept;
    logic [SAMPLE_W-1:0] lane0;
    logic [LANES-1:0]    lane_ok;
    logic                s1_valid;
    logic [LANES-1:0]    s1_ok;
    logic [SAMPLE_W-1:0] s1_lane0;
    logic [SAMPLE_W-1:0] exp_base;
    logic [31:0]         cons_bad;
    logic                intra_ok;
    logic                inter_ok;
    logic                beat_bad;
    logic [LANE_W-1:0]   fail_lane;

    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign ready_bit = (READY_MODE == 0) ? 1'b1 : lfsr[0];
    assign accept    = s_axis_tvalid & s_axis_tready;
    assign lane0     = s_axis_tdata[SAMPLE_W-1:0];
    assign locked    = (state == TRACK);

    // Ready generation; the LFSR free-runs so backpressure is independent of traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr          <= LFSR_SEED;
            s_axis_tready <= 1'b0;
        end else begin
            lfsr          <= clear ? LFSR_SEED : {lfsr[14:0], lfsr_fb};
            s_axis_tready <= enable & ready_bit;
        end
    end

    // Intra-beat compare of every lane against lane 0.
    always_comb begin
        lane_ok = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_ok[i] = (s_axis_tdata[i*SAMPLE_W +: SAMPLE_W] ==
                          SAMPLE_W'(lane0 + SAMPLE_W'(i * STEP)));
        end
    end

    // Stage 1 holds the compare vector and lane 0. A clear drops the beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ok    <= '0;
            s1_lane0 <= '0;
        end else begin
            s1_valid <= accept & ~clear;
            if (accept) begin
                s1_ok    <= lane_ok;
                s1_lane0 <= lane0;
            end
        end
    end

    // Stage 2 reduction and next state. An inter-beat failure makes lane 0 the
    // lowest failing lane; otherwise the lowest failing intra-beat lane is used.
    always_comb begin
        state_next = state;
        intra_ok   = &s1_ok;
        inter_ok   = (s1_lane0 == exp_base);
        beat_bad   = 1'b0;
        fail_lane  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (!s1_ok[i]) fail_lane = LANE_W'(i);
        end
        if (!inter_ok) fail_lane = '0;
        if (s1_valid) begin
            case (state)
                ACQUIRE: if (intra_ok) state_next = TRACK;
                TRACK: begin
                    beat_bad = ~(intra_ok & inter_ok);
                    if (beat_bad && cons_bad >= LIMIT_M1) state_next = ACQUIRE;
                end
                default: state_next = ACQUIRE;
            endcase
        end
        if (clear) state_next = ACQUIRE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACQUIRE;
        else     state <= state_next;
    end

    // Counters, expected base and first-error capture. The expected base always
    // reloads from the received lane 0, so a single glitch cannot cascade.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_base       <= '0;
            cons_bad       <= '0;
            beat_count     <= '0;
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_beat <= '0;
            first_err_lane <= '0;
        end else if (clear) begin
            exp_base       <= '0;
            cons_bad       <= '0;
            beat_count     <= '0;
            err_count      <= '0;
            err_flag       <= 1'b0;
            first_err_beat <= '0;
            first_err_lane <= '0;
        end else if (s1_valid) begin
            if (beat_count != '1) beat_count <= beat_count + 32'd1;
            if (state == ACQUIRE) begin
                cons_bad <= '0;
                if (intra_ok) exp_base <= s1_lane0 + BEAT_STEP;
            end else begin
                exp_base <= s1_lane0 + BEAT_STEP;
                if (beat_bad) begin
                    if (err_count != '1) err_count <= err_count + 32'd1;
                    cons_bad <= (cons_bad >= LIMIT_M1) ? 32'd0 : cons_bad + 32'd1;
                    if (!err_flag) begin
                        err_flag       <= 1'b1;
                        first_err_beat <= beat_count;
                        first_err_lane <= fail_lane;
                    end
                end else begin
                    cons_bad <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_ramp_checker.sv
// tb_axis_ramp_checker
// Directed bench for axis_ramp_checker. dut0 uses the always-ready mode,
// dut1 uses LFSR backpressure.

module tb_axis_ramp_checker;

    logic         clk = 1'b0;
    logic         rst;

    logic [511:0] tdata0;
    logic         tvalid0, tready0, enable0, clear0;
    logic         locked0, err_flag0;
    logic [31:0]  beat_count0, err_count0, first_err_beat0;
    logic [4:0]   first_err_lane0;

    logic [511:0] tdata1;
    logic         tvalid1, tready1, enable1, clear1;
    logic         locked1, err_flag1;
    logic [31:0]  beat_count1, err_count1, first_err_beat1;
    logic [4:0]   first_err_lane1;

    int           checks = 0;
    int           failures = 0;
    logic [15:0]  base;
    logic [15:0]  base1;
    logic [511:0] glitch;
    int           handshakes;
    int           ready_ones;
    logic         prev_ready;

    axis_ramp_checker dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata0), .s_axis_tvalid(tvalid0), .s_axis_tready(tready0),
        .enable(enable0), .clear(clear0),
        .locked(locked0), .err_flag(err_flag0),
        .beat_count(beat_count0), .err_count(err_count0),
        .first_err_beat(first_err_beat0), .first_err_lane(first_err_lane0)
    );

    axis_ramp_checker #(.READY_MODE(1), .LFSR_SEED(16'hACE1)) dut1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata1), .s_axis_tvalid(tvalid1), .s_axis_tready(tready1),
        .enable(enable1), .clear(clear1),
        .locked(locked1), .err_flag(err_flag1),
        .beat_count(beat_count1), .err_count(err_count1),
        .first_err_beat(first_err_beat1), .first_err_lane(first_err_lane1)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Ramp beat: lane i = b + i.
    function automatic logic [511:0] make_beat(input logic [15:0] b);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < 32; i++) d[i*16 +: 16] = b + 16'(i);
        return d;
    endfunction

    // Drive dut0 inputs on the falling edge, one beat per call.
    task automatic applyStimulus(input logic valid, input logic [511:0] data, input logic clr);
        @(negedge clk);
        tvalid0 = valid;
        tdata0  = data;
        clear0  = clr;
    endtask

    // Idle until the last driven beat has passed both pipeline stages.
    task automatic flush();
        applyStimulus(1'b0, '0, 1'b0);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        tdata0 = '0; tvalid0 = 1'b0; enable0 = 1'b0; clear0 = 1'b0;
        tdata1 = '0; tvalid1 = 1'b0; enable1 = 1'b0; clear1 = 1'b0;
        base = '0; base1 = '0; handshakes = 0; ready_ones = 0; prev_ready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_tready0", 32'(tready0), 32'd0);
        checkOutput("rst_locked0", 32'(locked0), 32'd0);
        checkOutput("rst_beat_count0", beat_count0, 32'd0);
        checkOutput("rst_err_flag0", 32'(err_flag0), 32'd0);
        checkOutput("rst_tready1", 32'(tready1), 32'd0);
        rst = 1'b0;
        enable0 = 1'b1;
        @(negedge clk);
        checkOutput("tready_rise", 32'(tready0), 32'd1);

        // Clean ramp of 100 beats, lane i of beat k = 32k + i.
        $display("[TB] clean ramp");
        base = 16'h0000;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, make_beat(base), 1'b0);
            base = base + 16'd32;
            if (k == 1) checkOutput("lock_latency_early", 32'(locked0), 32'd0);
            if (k == 2) checkOutput("lock_latency", 32'(locked0), 32'd1);
        end
        flush();
        checkOutput("ramp_beat_count", beat_count0, 32'd100);
        checkOutput("ramp_err_count", err_count0, 32'd0);
        checkOutput("ramp_err_flag", 32'(err_flag0), 32'd0);
        checkOutput("ramp_locked", 32'(locked0), 32'd1);

        // Clear with no traffic.
        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0);
        checkOutput("clear_beat_count", beat_count0, 32'd0);
        checkOutput("clear_locked", 32'(locked0), 32'd0);

        // Ramp across the 16-bit wrap.
        $display("[TB] wrap");
        base = 16'hFFF0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, make_beat(base), 1'b0);
            base = base + 16'd32;
        end
        flush();
        checkOutput("wrap_beat_count", beat_count0, 32'd4);
        checkOutput("wrap_err_count", err_count0, 32'd0);
        checkOutput("wrap_locked", 32'(locked0), 32'd1);

        // Lane 7 of beat 10 corrupted in a 50-beat ramp.
        $display("[TB] single glitch");
        applyStimulus(1'b0, '0, 1'b1);
        base = 16'h0000;
        for (int k = 0; k < 50; k++) begin
            glitch = make_beat(base);
            if (k == 10) glitch[7*16 +: 16] = glitch[7*16 +: 16] ^ 16'h0001;
            applyStimulus(1'b1, glitch, 1'b0);
            base = base + 16'd32;
        end
        flush();
        checkOutput("glitch_beat_count", beat_count0, 32'd50);
        checkOutput("glitch_err_count", err_count0, 32'd1);
        checkOutput("glitch_err_flag", 32'(err_flag0), 32'd1);
        checkOutput("glitch_first_beat", first_err_beat0, 32'd10);
        checkOutput("glitch_first_lane", 32'(first_err_lane0), 32'd7);
        checkOutput("glitch_locked", 32'(locked0), 32'd1);

        // Four consecutive lane-0 jumps drop lock; a clean beat re-locks.
        $display("[TB] lock loss");
        applyStimulus(1'b0, '0, 1'b1);
        base = 16'h1000;
        applyStimulus(1'b1, make_beat(base), 1'b0);
        for (int j = 0; j < 4; j++) begin
            base = base + 16'd32 + 16'd1000;
            applyStimulus(1'b1, make_beat(base), 1'b0);
        end
        flush();
        checkOutput("loss_err_count", err_count0, 32'd4);
        checkOutput("loss_locked", 32'(locked0), 32'd0);
        checkOutput("loss_first_beat", first_err_beat0, 32'd1);
        checkOutput("loss_first_lane", 32'(first_err_lane0), 32'd0);
        base = 16'h4000;
        applyStimulus(1'b1, make_beat(base), 1'b0);
        flush();
        checkOutput("relock_locked", 32'(locked0), 32'd1);
        checkOutput("relock_err_count", err_count0, 32'd4);
        checkOutput("relock_beat_count", beat_count0, 32'd6);

        // Clear on the same edge as a beat, with another beat in flight.
        $display("[TB] clear with beat");
        base = base + 16'd32;
        applyStimulus(1'b1, make_beat(base), 1'b0);
        base = base + 16'd32;
        applyStimulus(1'b1, make_beat(base), 1'b1);
        flush();
        checkOutput("clrbeat_beat_count", beat_count0, 32'd0);
        checkOutput("clrbeat_err_count", err_count0, 32'd0);
        checkOutput("clrbeat_err_flag", 32'(err_flag0), 32'd0);
        checkOutput("clrbeat_locked", 32'(locked0), 32'd0);
        checkOutput("clrbeat_first_beat", first_err_beat0, 32'd0);

        // LFSR backpressure on dut1 with tvalid held high for 1000 cycles.
        $display("[TB] backpressure");
        @(negedge clk);
        enable1 = 1'b1;
        base1 = 16'h0100;
        tvalid1 = 1'b1;
        tdata1 = make_beat(base1);
        prev_ready = tready1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (prev_ready) begin
                handshakes++;
                base1 = base1 + 16'd32;
                tdata1 = make_beat(base1);
            end
            if (tready1) ready_ones++;
            prev_ready = tready1;
        end
        tvalid1 = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] handshakes=%0d ready_high=%0d", handshakes, ready_ones);
        checkOutput("bp_beat_count", beat_count1, 32'(handshakes));
        checkOutput("bp_err_count", err_count1, 32'd0);
        checkOutput("bp_locked", 32'(locked1), 32'd1);
        checkOutput("bp_duty", 32'((ready_ones >= 400) && (ready_ones <= 600)), 32'd1);

        // Asynchronous reset in the middle of a stream.
        $display("[TB] mid-stream reset");
        base = 16'h2000;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, make_beat(base), 1'b0);
            base = base + 16'd32;
        end
        applyStimulus(1'b1, make_beat(base), 1'b0);
        checkOutput("pre_rst_beat_count", beat_count0, 32'd2);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_tready0", 32'(tready0), 32'd0);
        checkOutput("async_rst_tready1", 32'(tready1), 32'd0);
        checkOutput("async_rst_beat_count", beat_count0, 32'd0);
        checkOutput("async_rst_locked", 32'(locked0), 32'd0);
        checkOutput("async_rst_beat_count1", beat_count1, 32'd0);
        applyStimulus(1'b0, '0, 1'b0);
        rst = 1'b0;
        flush();
        checkOutput("post_rst_beat_count", beat_count0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
